// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state types for the sequential ALU core.
// No logic of its own; latency n/a.
// Backpressure n/a.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_ADC   = 4'd6,
        OP_SBB   = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_SAR   = 4'd10,
        OP_ROL   = 4'd11,
        OP_MUL   = 4'd12,
        OP_PASS  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift/rotate opcodes share the one-bit-per-cycle datapath.
    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shifter / shift-add multiplier, one bit per cycle, owns the step counter.
// Latency: shift amount (or WIDTH for MUL) cycles after start; done_o flags the final step.
// No backpressure: once started it runs to completion; the caller holds the result.
module alu_iter_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             last_out_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    alu_op_e          op_q;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] mcand_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             out_bit;
    logic [WIDTH:0]   mul_sum;

    // One step of the selected operation, computed from the current working registers.
    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        out_bit = 1'b0;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        case (op_q)
            OP_SHL: begin
                out_bit = lo_q[WIDTH-1];
                lo_d    = {lo_q[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
                out_bit = lo_q[0];
                lo_d    = {1'b0, lo_q[WIDTH-1:1]};
            end
            OP_SAR: begin
                out_bit = lo_q[0];
                lo_d    = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
            end
            OP_ROL: begin
                out_bit = lo_q[WIDTH-1];
                lo_d    = {lo_q[WIDTH-2:0], lo_q[WIDTH-1]};
            end
            OP_MUL: begin
                // Multiplier sits in lo and drains out the bottom as the product fills in.
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // Capture operands on start, then advance one step per cycle until the count expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_ADD;
            lo_q    <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            op_q    <= op_i;
            lo_q    <= a_i;
            hi_q    <= '0;
            mcand_q <= b_i;
            cnt_q   <= (op_i == OP_MUL) ? CNT_MUL : CW'(b_i[SHW-1:0]);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The final step's result is presented combinationally so the caller registers it that same edge.
    assign done_o     = busy_q && (cnt_q == CNT_ONE);
    assign res_lo_o   = lo_d;
    assign res_hi_o   = hi_d;
    assign last_out_o = out_bit;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: one-cycle ops plus iterative shifts/multiply, with a stored carry for ADC/SBB chains.
// Latency: 1 cycle for simple ops and zero shifts, n+1 for shift by n, WIDTH+1 for MUL.
// Result is held stable while Out_Valid & !Out_Ready; In_Ready drops during EXEC and stalled output.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Alu_Sel,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Alu_Out,
    output logic [WIDTH-1:0] Alu_Out_Hi,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    alu_op_e          op_in;
    logic             accept, go_iter, iter_start;
    logic             iter_done, iter_last;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic             out_vld_q, carry_q, zero_q, neg_q, ovf_q, ill_q, mul_q;
    logic [WIDTH-1:0] res_q, res_hi_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r1;
    logic             c1, v1, ill1;

    assign op_in    = alu_op_e'(Alu_Sel);
    assign go_iter  = (op_in == OP_MUL) || (is_shift(op_in) && (B[SHW-1:0] != '0));
    assign In_Ready = ((state_q == IDLE) && !out_vld_q) ||
                      (out_vld_q && Out_Ready && (state_q != EXEC));
    assign accept   = In_Valid && In_Ready;

    // Single-cycle datapath; zero-distance shifts pass A through and keep the stored carry.
    always_comb begin
        sum  = '0;
        r1   = '0;
        c1   = carry_q;
        v1   = 1'b0;
        ill1 = 1'b0;
        case (op_in)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, A} + {1'b0, B} +
                      ((op_in == OP_ADC) ? {{WIDTH{1'b0}}, carry_q} : {(WIDTH+1){1'b0}});
                r1  = sum[WIDTH-1:0];
                c1  = sum[WIDTH];
                v1  = (A[MSB] == B[MSB]) && (r1[MSB] != A[MSB]);
            end
            OP_SUB, OP_SBB: begin
                sum = {1'b0, A} - {1'b0, B} -
                      ((op_in == OP_SBB) ? {{WIDTH{1'b0}}, carry_q} : {(WIDTH+1){1'b0}});
                r1  = sum[WIDTH-1:0];
                c1  = sum[WIDTH];
                v1  = (A[MSB] != B[MSB]) && (r1[MSB] != A[MSB]);
            end
            OP_AND:  r1 = A & B;
            OP_OR:   r1 = A | B;
            OP_XOR:  r1 = A ^ B;
            OP_NOT:  r1 = ~A;
            OP_PASS: r1 = A;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL: r1 = A;
            OP_MUL:  r1 = '0;
            default: ill1 = 1'b1;
        endcase
    end

    // FSM next-state: back-to-back accepts from DONE keep throughput at one per cycle.
    always_comb begin
        state_d    = state_q;
        iter_start = accept && go_iter;
        case (state_q)
            IDLE: if (accept) state_d = go_iter ? EXEC : DONE;
            EXEC: if (iter_done) state_d = DONE;
            DONE: if (Out_Ready) state_d = accept ? (go_iter ? EXEC : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result/flag registers; the Carry output register doubles as the stored carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            res_q     <= '0;
            res_hi_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ill_q     <= 1'b0;
            mul_q     <= 1'b0;
        end else if (accept && !go_iter) begin
            out_vld_q <= 1'b1;
            res_q     <= r1;
            res_hi_q  <= '0;
            carry_q   <= c1;
            zero_q    <= (r1 == '0);
            neg_q     <= r1[MSB];
            ovf_q     <= v1;
            ill_q     <= ill1;
        end else if (accept) begin
            out_vld_q <= 1'b0;
            mul_q     <= (op_in == OP_MUL);
        end else if ((state_q == EXEC) && iter_done) begin
            out_vld_q <= 1'b1;
            res_q     <= iter_lo;
            res_hi_q  <= mul_q ? iter_hi : '0;
            carry_q   <= mul_q ? (iter_hi != '0) : iter_last;
            zero_q    <= mul_q ? ({iter_hi, iter_lo} == '0) : (iter_lo == '0);
            neg_q     <= iter_lo[MSB];
            ovf_q     <= mul_q && (iter_hi != '0);
            ill_q     <= 1'b0;
        end else if (out_vld_q && Out_Ready) begin
            out_vld_q <= 1'b0;
        end
    end

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start_i   (iter_start),
        .op_i      (op_in),
        .a_i       (A),
        .b_i       (B),
        .done_o    (iter_done),
        .res_hi_o  (iter_hi),
        .res_lo_o  (iter_lo),
        .last_out_o(iter_last)
    );

    assign Out_Valid  = out_vld_q;
    assign Alu_Out    = res_q;
    assign Alu_Out_Hi = res_hi_q;
    assign Carry      = carry_q;
    assign Zero       = zero_q;
    assign Negative   = neg_q;
    assign Overflow   = ovf_q;
    assign Illegal    = ill_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8 with hand-computed expected results.
// Latency is checked cycle by cycle after each accept.
// Covers output stall, mid-operation reset, and reserved opcodes.
module tb_alu_seq_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] A, B;
    logic [3:0] Alu_Sel;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [7:0] Alu_Out, Alu_Out_Hi;
    logic       Carry, Zero, Negative, Overflow, Illegal;

    int checks = 0;
    int errors = 0;

    alu_seq_core #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
        .Alu_Sel   (Alu_Sel),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Alu_Out   (Alu_Out),
        .Alu_Out_Hi(Alu_Out_Hi),
        .Carry     (Carry),
        .Zero      (Zero),
        .Negative  (Negative),
        .Overflow  (Overflow),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one beat, confirm it is accepted on the next edge, then scramble the operand bus.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
        Alu_Sel  = op;
        A        = a;
        B        = b;
        In_Valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, {31'd0, In_Ready}, 32'd1);
        step;
        In_Valid = 1'b0;
        A        = ~a;
        B        = ~b;
        Alu_Sel  = 4'd0;
    endtask

    // Out_Valid must stay low (and In_Ready low) until exactly lat cycles after the accept.
    task automatic wait_res(input int lat, input string tag);
        for (int i = 1; i < lat; i++) begin
            chk({tag, "_busy"}, {30'd0, In_Ready, Out_Valid}, 32'd0);
            step;
        end
        chk({tag, "_vld"}, {31'd0, Out_Valid}, 32'd1);
    endtask

    // flags order: {Carry, Zero, Negative, Overflow}
    task automatic res(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [3:0] flags, input logic ill);
        chk({tag, "_lo"},    {24'd0, Alu_Out}, {24'd0, lo});
        chk({tag, "_hi"},    {24'd0, Alu_Out_Hi}, {24'd0, hi});
        chk({tag, "_flags"}, {28'd0, Carry, Zero, Negative, Overflow}, {28'd0, flags});
        chk({tag, "_ill"},   {31'd0, Illegal}, {31'd0, ill});
    endtask

    task automatic drain(input string tag);
        step;
        chk({tag, "_drain"}, {31'd0, Out_Valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        A         = 8'h00;
        B         = 8'h00;
        Alu_Sel   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {10'd0, Out_Valid, Alu_Out, Alu_Out_Hi, Carry, Zero, Negative, Overflow, Illegal}, 32'd0);
        rst = 1'b0;
        step;

        // Back-to-back single-cycle beats; ADC picks up the carry the ADD just produced.
        issue(4'd0, 8'hE2, 8'h5D, "add");
        wait_res(1, "add");
        res("add", 8'h3F, 8'h00, 4'b1000, 1'b0);
        issue(4'd6, 8'h01, 8'hFE, "adc");
        wait_res(1, "adc");
        res("adc", 8'h00, 8'h00, 4'b1100, 1'b0);
        issue(4'd1, 8'hE2, 8'h5D, "sub");
        wait_res(1, "sub");
        res("sub", 8'h85, 8'h00, 4'b0010, 1'b0);
        drain("sub");

        // Multiply: 0xF0 * 0x0F = 0x0E10, valid 9 cycles after accept.
        issue(4'd12, 8'hF0, 8'h0F, "mul");
        wait_res(9, "mul");
        res("mul", 8'h10, 8'h0E, 4'b1001, 1'b0);
        drain("mul");

        // Shifts and rotate.
        issue(4'd8, 8'h55, 8'h03, "shl");
        wait_res(4, "shl");
        res("shl", 8'hA8, 8'h00, 4'b0010, 1'b0);
        drain("shl");
        issue(4'd10, 8'h80, 8'h07, "sar");
        wait_res(8, "sar");
        res("sar", 8'hFF, 8'h00, 4'b0010, 1'b0);
        drain("sar");
        issue(4'd11, 8'h81, 8'h01, "rol");
        wait_res(2, "rol");
        res("rol", 8'h03, 8'h00, 4'b1000, 1'b0);
        drain("rol");

        // Signed overflow boundary, then a zero-distance shift must keep the carry.
        issue(4'd0, 8'h80, 8'h80, "addovf");
        wait_res(1, "addovf");
        res("addovf", 8'h00, 8'h00, 4'b1101, 1'b0);
        issue(4'd9, 8'h5A, 8'h08, "shr0");
        wait_res(1, "shr0");
        res("shr0", 8'h5A, 8'h00, 4'b1000, 1'b0);
        drain("shr0");

        // Stall: result held with a pending beat waiting, then exactly one accept on release.
        Out_Ready = 1'b0;
        issue(4'd2, 8'hF0, 8'h0F, "and");
        wait_res(1, "and");
        res("and", 8'h00, 8'h00, 4'b1100, 1'b0);
        Alu_Sel  = 4'd0;
        A        = 8'h03;
        B        = 8'h04;
        In_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold", {21'd0, In_Ready, Out_Valid, Alu_Out, Zero}, {21'd0, 1'b0, 1'b1, 8'h00, 1'b1});
            step;
        end
        Out_Ready = 1'b1;
        #1;
        chk("release_rdy", {31'd0, In_Ready}, 32'd1);
        step;
        In_Valid = 1'b0;
        chk("release_vld", {31'd0, Out_Valid}, 32'd1);
        res("release", 8'h07, 8'h00, 4'b0000, 1'b0);
        drain("release");

        // Reset three cycles into a multiply: outputs clear without waiting for an edge.
        issue(4'd12, 8'hF0, 8'h0F, "mulrst");
        step;
        step;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {10'd0, Out_Valid, Alu_Out, Alu_Out_Hi, Carry, Zero, Negative, Overflow, Illegal}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            chk("no_result_after_rst", {31'd0, Out_Valid}, 32'd0);
        end
        issue(4'd0, 8'h01, 8'h01, "add_post");
        wait_res(1, "add_post");
        res("add_post", 8'h02, 8'h00, 4'b0000, 1'b0);

        // Reserved opcodes, then ADC confirms the stored carry was not disturbed.
        issue(4'd14, 8'h12, 8'h34, "rsv14");
        wait_res(1, "rsv14");
        res("rsv14", 8'h00, 8'h00, 4'b0100, 1'b1);
        issue(4'd15, 8'hFF, 8'hFF, "rsv15");
        wait_res(1, "rsv15");
        res("rsv15", 8'h00, 8'h00, 4'b0100, 1'b1);
        issue(4'd6, 8'h00, 8'h00, "adc_after");
        wait_res(1, "adc_after");
        res("adc_after", 8'h00, 8'h00, 4'b0100, 1'b0);
        drain("adc_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
